// File: rtl/instruction_fetch.sv
// instruction_fetch: holds the PC, fetches words over req/ack,
// hands them to decode over valid/ready and steps the PC.
// Ports: iClk, iRst (sync, active-high)
//   imem  : oMemReq, oMemAddr, iMemAck, iMemData
//   decode: oValid, iReady, oInstruction, oPC, iPCSrc, iImmExt
//   status: oFault (sticky misaligned PC), oFetchCount
module instruction_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          COUNT_WIDTH = 32
) (
  input  logic                   iClk,
  input  logic                   iRst,
  output logic                   oMemReq,
  output logic [31:0]            oMemAddr,
  input  logic                   iMemAck,
  input  logic [31:0]            iMemData,
  output logic                   oValid,
  input  logic                   iReady,
  output logic [31:0]            oInstruction,
  output logic [31:0]            oPC,
  input  logic                   iPCSrc,
  input  logic [31:0]            iImmExt,
  output logic                   oFault,
  output logic [COUNT_WIDTH-1:0] oFetchCount
);

  typedef enum logic [1:0] {
    START,
    FETCH,
    HOLD,
    FAULT
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [31:0]            r_pc;
  logic [31:0]            r_instr;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [31:0]            w_target;
  logic                   w_misal;
  logic                   w_fire;
  logic                   w_capture;

  always_comb begin
    w_next    = r_state;
    w_fire    = 1'b0;
    w_capture = 1'b0;
    w_target  = iPCSrc ? r_pc + iImmExt
                       : r_pc + 32'd4;
    w_misal   = |w_target[1:0];
    unique case (r_state)
      START: w_next = FETCH;
      FETCH: begin
        if (iMemAck) begin
          w_capture = 1'b1;
          w_next    = HOLD;
        end
      end
      HOLD: begin
        if (iReady) begin
          w_fire = 1'b1;
          w_next = w_misal ? FAULT : FETCH;
        end
      end
      FAULT: w_next = FAULT;
      default: w_next = START;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= START;
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_capture) begin
        r_instr <= iMemData;
      end
      if (w_fire) begin
        r_count <= r_count + COUNT_WIDTH'(1);
        // a misaligned target leaves the last good PC visible
        if (!w_misal) begin
          r_pc <= w_target;
        end
      end
    end
  end

  assign oMemReq      = (r_state == FETCH);
  assign oValid       = (r_state == HOLD);
  assign oFault       = (r_state == FAULT);
  assign oMemAddr     = r_pc;
  assign oPC          = r_pc;
  assign oInstruction = r_instr;
  assign oFetchCount  = r_count;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: random + directed fetch traffic,
// reference PC model and scoreboard queues drained by a monitor.
module tb_instruction_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } pair_t;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        oMemReq;
  logic [31:0] oMemAddr;
  logic        iMemAck = 1'b0;
  logic [31:0] iMemData = '0;
  logic        oValid;
  logic        iReady = 1'b0;
  logic [31:0] oInstruction;
  logic [31:0] oPC;
  logic        iPCSrc = 1'b0;
  logic [31:0] iImmExt = '0;
  logic        oFault;
  logic [31:0] oFetchCount;

  instruction_fetch #(
    .RESET_PC   (RST_PC),
    .COUNT_WIDTH(32)
  ) dut (
    .iClk        (iClk),
    .iRst        (iRst),
    .oMemReq     (oMemReq),
    .oMemAddr    (oMemAddr),
    .iMemAck     (iMemAck),
    .iMemData    (iMemData),
    .oValid      (oValid),
    .iReady      (iReady),
    .oInstruction(oInstruction),
    .oPC         (oPC),
    .iPCSrc      (iPCSrc),
    .iImmExt     (iImmExt),
    .oFault      (oFault),
    .oFetchCount (oFetchCount)
  );

  always #5 iClk = ~iClk;

  int n_checks = 0;
  int n_fail   = 0;

  // expected fetch: {addr, count}; presented: {pc, instr};
  // fault: {pc, count}
  pair_t addr_q[$];
  pair_t data_q[$];
  pair_t fault_q[$];

  logic [31:0] model_pc;
  logic [31:0] model_count;
  bit          mon_en = 1'b0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // monitor: pops expectations on rising handshakes and
  // checks that presented values stay stable afterwards
  initial begin
    bit          p_req = 0;
    bit          p_val = 0;
    bit          p_flt = 0;
    logic [31:0] l_addr = '0;
    logic [31:0] l_pc = '0;
    logic [31:0] l_ins = '0;
    logic [31:0] f_pc = '0;
    pair_t       e;
    forever begin
      @(negedge iClk);
      if (mon_en) begin
        if (oMemReq === 1'b1 && !p_req) begin
          if (addr_q.size() == 0) begin
            chk("unexpected_req", 32'd1, 32'd0);
          end else begin
            e = addr_q.pop_front();
            chk("fetch_addr", oMemAddr, e.a);
            chk("fetch_pc", oPC, e.a);
            chk("fetch_count", oFetchCount, e.b);
          end
          l_addr = oMemAddr;
        end else if (oMemReq === 1'b1) begin
          chk("req_addr_stable", oMemAddr, l_addr);
        end
        if (oValid === 1'b1 && !p_val) begin
          if (data_q.size() == 0) begin
            chk("unexpected_valid", 32'd1, 32'd0);
          end else begin
            e = data_q.pop_front();
            chk("present_pc", oPC, e.a);
            chk("present_instr", oInstruction, e.b);
          end
          l_pc  = oPC;
          l_ins = oInstruction;
        end else if (oValid === 1'b1) begin
          chk("stall_pc", oPC, l_pc);
          chk("stall_instr", oInstruction, l_ins);
        end
        if (oFault === 1'b1 && !p_flt) begin
          if (fault_q.size() == 0) begin
            chk("unexpected_fault", 32'd1, 32'd0);
          end else begin
            e = fault_q.pop_front();
            chk("fault_pc", oPC, e.a);
            chk("fault_count", oFetchCount, e.b);
          end
          f_pc = oPC;
        end else if (oFault === 1'b1) begin
          chk("fault_pc_hold", oPC, f_pc);
          chk("fault_no_req", 32'(oMemReq), 32'd0);
          chk("fault_no_valid", 32'(oValid), 32'd0);
        end
      end
      p_req = (oMemReq === 1'b1);
      p_val = (oValid === 1'b1);
      p_flt = (oFault === 1'b1);
    end
  end

  task automatic do_reset();
    iRst    = 1'b1;
    iReady  = 1'b0;
    iMemAck = 1'b0;
    @(negedge iClk);
    chk("rst_req", 32'(oMemReq), 32'd0);
    chk("rst_valid", 32'(oValid), 32'd0);
    chk("rst_fault", 32'(oFault), 32'd0);
    chk("rst_pc", oPC, RST_PC);
    chk("rst_instr", oInstruction, 32'd0);
    chk("rst_count", oFetchCount, 32'd0);
    addr_q.delete();
    data_q.delete();
    fault_q.delete();
    model_pc    = RST_PC;
    model_count = 0;
    addr_q.push_back({RST_PC, 32'd0});
    mon_en = 1'b1;
    // stale ack while in START must be ignored
    iRst     = 1'b0;
    iMemAck  = 1'b1;
    iMemData = 32'hDEAD_BEEF;
    @(negedge iClk);
    chk("first_req", 32'(oMemReq), 32'd1);
    chk("start_ack_ignored", oInstruction, 32'd0);
    iMemAck = 1'b0;
  endtask

  // one full fetch: waits ack-less cycles, stall cycles
  // of iReady=0, then a fire with the given PCSrc/ImmExt
  task automatic do_instr(int waits, int stall, bit pcsrc,
                          logic [31:0] imm);
    logic [31:0] d;
    logic [31:0] nxt;
    chk("req_immediate", 32'(oMemReq), 32'd1);
    for (int w = 0; w < waits; w++) begin
      iMemAck  = 1'b0;
      iMemData = $urandom;
      @(negedge iClk);
    end
    d        = $urandom;
    iMemAck  = 1'b1;
    iMemData = d;
    data_q.push_back({model_pc, d});
    @(negedge iClk);
    iMemAck  = 1'b0;
    iMemData = $urandom;
    chk("ack_to_valid", 32'(oValid), 32'd1);
    for (int s = 0; s < stall; s++) begin
      iReady  = 1'b0;
      iPCSrc  = 1'($urandom);
      iImmExt = $urandom;
      @(negedge iClk);
    end
    iReady  = 1'b1;
    iPCSrc  = pcsrc;
    iImmExt = imm;
    nxt = pcsrc ? model_pc + imm : model_pc + 32'd4;
    model_count = model_count + 1;
    if (nxt[1:0] != 2'b00) begin
      fault_q.push_back({model_pc, model_count});
    end else begin
      model_pc = nxt;
      addr_q.push_back({nxt, model_count});
    end
    @(negedge iClk);
    iReady  = 1'b0;
    iPCSrc  = 1'b0;
    iImmExt = $urandom;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) @(negedge iClk);
  endtask

  initial begin
    logic [31:0] imm;
    int          k;
    @(negedge iClk);
    do_reset();
    // straight-line, zero-wait: 0x0, 0x4, 0x8
    for (int i = 0; i < 3; i++) do_instr(0, 0, 1'b0, 32'h0);
    // 3 wait states with toggling data at 0xC
    do_instr(3, 0, 1'b0, 32'h0);
    // branch to 0x100, stall 5, branch back by 16
    do_instr(0, 0, 1'b1, 32'h100 - model_pc);
    do_instr(0, 5, 1'b1, 32'hFFFF_FFF0);
    // jump to top of memory, then wrap on +4
    do_instr(1, 0, 1'b1, 32'hFFFF_FFFC - model_pc);
    do_instr(0, 0, 1'b0, 32'h0);
    // to 0x20, then a misaligned branch faults
    do_instr(0, 1, 1'b1, 32'h20 - model_pc);
    do_instr(0, 0, 1'b1, 32'h6);
    idle(4);
    do_reset();
    // reset during a FETCH wait
    do_instr(0, 0, 1'b0, 32'h0);
    iMemAck = 1'b0;
    idle(2);
    do_reset();
    // reset while presenting an instruction
    do_instr(2, 1, 1'b0, 32'h0);
    iMemAck  = 1'b1;
    iMemData = 32'h0000_0013;
    data_q.push_back({model_pc, 32'h0000_0013});
    @(negedge iClk);
    iMemAck = 1'b0;
    idle(1);
    do_reset();
    // random traffic
    for (int n = 0; n < 200; n++) begin
      k   = $urandom_range(0, 63);
      imm = 32'((k - 32) * 4);
      if ($urandom_range(0, 24) == 0) begin
        imm = imm | 32'($urandom_range(1, 3));
        do_instr($urandom_range(0, 3), $urandom_range(0, 3),
                 1'b1, imm);
        idle(3);
        do_reset();
      end else begin
        do_instr($urandom_range(0, 3), $urandom_range(0, 3),
                 1'($urandom), imm);
      end
    end
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
